matrix_result_serializer: RTL and testbench
===========================================

Name: matrix_result_serializer

Overview:
- Downstream stage of the 3x3 combinational matrix multiplier.
- Captures the full N x N result matrix (N*N words of DW bits) in one handshake.
- Streams the words out one per beat, in row-major order, over a valid/ready interface to the next consumer (memory writer or UART packer).
- Decouples the wide combinational product from narrow sequential sinks.

Parameters:
- N, 3, matrix dimension (rows = cols); legal values 1..4.
- DW, 32, element width; matches multiplier output width.
- IW, 2, index width for out_row/out_col; must satisfy 2^IW >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_c holds a valid result matrix.
- in_ready  output  1  block can capture a matrix.
- in_c  input  N*N*DW  flattened matrix; element (i,j) at bits [(i*N+j)*DW +: DW].
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts the current beat.
- out_data  output  DW  current element.
- out_row  output  IW  row index of the current element.
- out_col  output  IW  column index of the current element.
- out_last  output  1  current beat is the final beat of the matrix.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Single clock (clk); synchronous active-high reset (rst).
- Reset values: in_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0; capture buffer cleared to 0; state=IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register all N*N words into the internal buffer, set index to (0,0), go to SEND.
  - SEND: in_ready=0, out_valid=1, out_data=buf[row][col].
- Latency: a capture at edge k presents element (0,0) with out_valid=1 after edge k (one cycle).
- Beat acceptance is out_valid&&out_ready:
  - Not the last beat: advance col; when col==N-1, col wraps to 0 and row increments.
  - Last beat (row==N-1, col==N-1): return to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - No new capture occurs in the same cycle as the last-beat acceptance, so there is one bubble between matrices.
- out_last=1 only while presenting (N-1,N-1) (base build).
- Stall: while out_valid&&!out_ready, out_data/out_row/out_col/out_last hold stable.
- in_c and in_valid are ignored outside IDLE; the buffer is never overwritten mid-stream.
- out_valid never deasserts without acceptance, except on rst.
- rst mid-stream: abort immediately, apply reset values; a partially sent matrix is discarded with no further beats.
- N=1: a single beat with out_last=1.
- No arithmetic on data; words pass through bit-exact.

Optional Feature:
- Macro: MATRIX_SER_CHECKSUM_EN.
- Defined:
  - Adds output port out_is_sum (1 bit) and state SUM after SEND.
  - The accumulator is cleared on capture and adds each word as its beat is accepted, modulo 2^DW.
  - After (N-1,N-1) is accepted, the FSM enters SUM and presents the accumulated sum with out_is_sum=1, out_row=0, out_col=0.
  - out_last moves from (N-1,N-1) to the SUM beat; total beats = N*N+1.
  - SUM-beat acceptance returns the FSM to IDLE.
  - The accumulator resets to 0.
- Not defined: no port, no SUM state; N*N beats; behaviour exactly as described above.

Test Plan:
- Basic stream:
  - Stimulus: capture C with element (i,j) = 10*i+j, out_ready tied 1.
  - Response: beats 0,1,2,10,11,12,20,21,22 on consecutive cycles; row/col match; out_last only on 22; in_ready returns 1 one cycle after beat 22.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,... during the same stream.
  - Response: no lost or duplicated beats; out_data holds its value throughout each stall; order unchanged.
- Input ignored while busy:
  - Stimulus: after capture, change in_c to all 0xFFFFFFFF and hold in_valid=1.
  - Response: the original 9 words stream out; the second matrix is captured only after IDLE is re-entered.
- Reset mid-stream:
  - Stimulus: assert rst after the 4th accepted beat.
  - Response: next cycle out_valid=0, in_ready=1, busy=0, out_data=0; a following capture streams from (0,0).
- Wide values:
  - Stimulus: elements 0xFFFF_FFFF and 0x8000_0001 at (1,1) and (2,2).
  - Response: output is bit-exact.
  - With MATRIX_SER_CHECKSUM_EN: the sum wraps mod 2^32, a 10th beat appears with out_is_sum=1 and out_last=1, and (2,2) has out_last=0.
- Back-to-back matrices:
  - Stimulus: in_valid held 1 with two different matrices in sequence.
  - Response: exactly one idle cycle between the last beat of matrix 1 and the first beat of matrix 2.

Source files
------------

// File: rtl/matrix_result_serializer.sv
// Captures an N x N result matrix in one handshake and streams it out row-major, one word per beat.
// Optional MATRIX_SER_CHECKSUM_EN appends a modulo-2^DW sum beat flagged by out_is_sum.
module matrix_result_serializer #(
  parameter int N  = 3,
  parameter int DW = 32,
  parameter int IW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*N*DW-1:0] in_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [IW-1:0]     out_row,
  output logic [IW-1:0]     out_col,
  output logic              out_last,
`ifdef MATRIX_SER_CHECKSUM_EN
  output logic              out_is_sum,
`endif
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // raised out_valid and its payload stay put until that transfer (or rst).
`ifdef MATRIX_SER_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_SUM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1} state_t;
`endif

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [N*N*DW-1:0]   r_buf;
  logic [IW-1:0]       r_row;
  logic [IW-1:0]       r_col;
  logic [DW-1:0]       w_word;
  logic                w_at_end;
  int                  w_idx;
`ifdef MATRIX_SER_CHECKSUM_EN
  logic [DW-1:0]       r_sum;
`endif

  always_comb begin
    w_idx    = int'(r_row) * N + int'(r_col);
    w_word   = r_buf[w_idx*DW +: DW];
    w_at_end = (r_row == LAST_IDX) && (r_col == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_next = ST_SEND;
`ifdef MATRIX_SER_CHECKSUM_EN
      ST_SEND: if (out_ready && w_at_end) w_state_next = ST_SUM;
      ST_SUM:  if (out_ready) w_state_next = ST_IDLE;
`else
      ST_SEND: if (out_ready && w_at_end) w_state_next = ST_IDLE;
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state != ST_IDLE);
    busy      = (r_state != ST_IDLE);
    dbg_state = r_state;
    out_row   = r_row;
    out_col   = r_col;
    out_data  = '0;
    out_last  = 1'b0;
`ifdef MATRIX_SER_CHECKSUM_EN
    out_is_sum = (r_state == ST_SUM);
    if (r_state == ST_SEND) out_data = w_word;
    if (r_state == ST_SUM) begin
      out_data = r_sum;
      out_last = 1'b1;
    end
`else
    if (r_state == ST_SEND) begin
      out_data = w_word;
      out_last = w_at_end;
    end
`endif
  end

  // Index returns to (0,0) after the final word so a sum beat reports row/col 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
      r_row <= '0;
      r_col <= '0;
`ifdef MATRIX_SER_CHECKSUM_EN
      r_sum <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_buf <= in_c;
            r_row <= '0;
            r_col <= '0;
`ifdef MATRIX_SER_CHECKSUM_EN
            r_sum <= '0;
`endif
          end
        end
        ST_SEND: begin
          if (out_ready) begin
`ifdef MATRIX_SER_CHECKSUM_EN
            r_sum <= r_sum + w_word;
`endif
            if (w_at_end) begin
              r_row <= '0;
              r_col <= '0;
            end else if (r_col == LAST_IDX) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench for matrix_result_serializer: captures push expected beats, accepted beats pop and compare.
// Follows MATRIX_SER_CHECKSUM_EN when defined (extra sum beat per matrix).
module tb_matrix_result_serializer;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int BW = DW + 2*IW + 2;
`ifdef MATRIX_SER_CHECKSUM_EN
  localparam int NB = N*N + 1;
`else
  localparam int NB = N*N;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N*N*DW-1:0] in_c;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_row;
  logic [IW-1:0]     out_col;
  logic              out_last;
  logic              busy;
  logic [1:0]        dbg_state;
  logic              tb_is_sum;

  matrix_result_serializer #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
`ifdef MATRIX_SER_CHECKSUM_EN
    .out_is_sum(tb_is_sum),
`endif
    .busy      (busy),
    .dbg_state (dbg_state)
  );
`ifndef MATRIX_SER_CHECKSUM_EN
  assign tb_is_sum = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(input logic is_sum, input logic last,
                                         input logic [IW-1:0] row, input logic [IW-1:0] col,
                                         input logic [DW-1:0] data);
    return {is_sum, last, row, col, data};
  endfunction

  // Expected-beat model: row-major words, last on (N-1,N-1) or on the sum beat.
  task automatic push_matrix(input logic [N*N*DW-1:0] m);
    logic [DW-1:0] sum;
    logic [DW-1:0] w;
    logic          last;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w   = m[(i*N+j)*DW +: DW];
        sum = sum + w;
`ifdef MATRIX_SER_CHECKSUM_EN
        last = 1'b0;
`else
        last = (i == N-1) && (j == N-1);
`endif
        exp_q.push_back(pack(1'b0, last, IW'(i), IW'(j), w));
      end
    end
`ifdef MATRIX_SER_CHECKSUM_EN
    exp_q.push_back(pack(1'b1, 1'b1, '0, '0, sum));
`endif
  endtask

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) push_matrix(in_c);
  end

  // Monitor: compares accepted beats, checks stall stability and post-last in_ready.
  int            acc_cnt   = 0;
  int            first_cyc = 0;
  int            last_cyc  = -100;
  int            gap       = 0;
  logic          stall_pend = 1'b0;
  logic          last_acc   = 1'b0;
  logic [BW-1:0] stall_snap;
  logic [BW-1:0] cur;
  logic [BW-1:0] exp_beat;

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
      last_acc   = 1'b0;
    end else begin
      cur = pack(tb_is_sum, out_last, out_row, out_col, out_data);
      if (last_acc) begin
        check("in_ready_after_last", 64'(in_ready), 64'(1));
        last_acc = 1'b0;
      end
      if (stall_pend) begin
        check("stall_hold", {out_valid, cur}, {1'b1, stall_snap});
        stall_pend = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          acc_cnt++;
          check("q_nonempty", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            exp_beat = exp_q.pop_front();
            check("beat", cur, exp_beat);
          end
          if (!tb_is_sum && out_row == '0 && out_col == '0) begin
            first_cyc = cyc;
            gap       = cyc - last_cyc;
          end
          if (out_last) begin
            last_cyc = cyc;
            last_acc = 1'b1;
          end
        end else begin
          stall_snap = cur;
          stall_pend = 1'b1;
        end
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  int rdy_mode = 0;
  int rdy_ph   = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          out_ready = (rdy_ph == 0);
          rdy_ph    = (rdy_ph + 1) % 3;
        end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_capture();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("capture_timeout", 64'(0), 64'(1));
    tick();
  endtask

  task automatic send_matrix(input logic [N*N*DW-1:0] m);
    in_valid = 1'b1;
    in_c     = m;
    wait_capture();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (n >= 600) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    tick();
    tick();
  endtask

  function automatic logic [N*N*DW-1:0] mk_mat(input int base);
    logic [N*N*DW-1:0] m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[(i*N+j)*DW +: DW] = DW'(base + 10*i + j);
    return m;
  endfunction

  logic [N*N*DW-1:0] m_basic;
  logic [N*N*DW-1:0] m_wide;
  logic [N*N*DW-1:0] m_rand;
  int base_cnt;
  int n_wait;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_c     = '0;
    m_basic  = mk_mat(0);
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_out_row",   64'(out_row),   64'(0));
    check("rst_out_col",   64'(out_col),   64'(0));
    check("rst_out_last",  64'(out_last),  64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    tick();
    rst = 1'b0;
    tick();

    // basic stream, always ready: beats on consecutive cycles
    send_matrix(m_basic);
    wait_drain();
    check("stream_span", 64'(last_cyc - first_cyc), 64'(NB - 1));

    // backpressure 1,0,0,...
    rdy_mode = 1;
    send_matrix(mk_mat(300));
    wait_drain();
    rdy_mode = 0;

    // input ignored while busy; the all-ones matrix is taken only after IDLE
    in_valid = 1'b1;
    in_c     = mk_mat(500);
    wait_capture();
    in_c     = '1;
    wait_capture();
    in_valid = 1'b0;
    wait_drain();
    check("ignored_gap", 64'(gap), 64'(2));

    // reset after the 4th accepted beat
    base_cnt = acc_cnt;
    in_valid = 1'b1;
    in_c     = mk_mat(700);
    wait_capture();
    in_valid = 1'b0;
    n_wait   = 0;
    while (acc_cnt < base_cnt + 4 && n_wait < 100) begin
      @(posedge clk);
      n_wait++;
    end
    if (n_wait >= 100) check("rst_wait_timeout", 64'(acc_cnt - base_cnt), 64'(4));
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    check("midrst_busy",      64'(busy),      64'(0));
    check("midrst_out_data",  64'(out_data),  64'(0));
    check("midrst_out_row",   64'(out_row),   64'(0));
    check("midrst_out_col",   64'(out_col),   64'(0));
    tick();
    rst = 1'b0;
    tick();
    send_matrix(mk_mat(900));
    wait_drain();

    // wide values, bit-exact (sum wraps when the checksum beat is present)
    m_wide = mk_mat(1);
    m_wide[(1*N+1)*DW +: DW] = 32'hFFFF_FFFF;
    m_wide[(2*N+2)*DW +: DW] = 32'h8000_0001;
    send_matrix(m_wide);
    wait_drain();

    // back-to-back matrices with in_valid held high
    in_valid = 1'b1;
    in_c     = mk_mat(1100);
    wait_capture();
    in_c     = mk_mat(1300);
    wait_capture();
    in_valid = 1'b0;
    wait_drain();
    check("b2b_gap", 64'(gap), 64'(2));

    // random data under random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) begin
      for (int e = 0; e < N*N; e++) m_rand[e*DW +: DW] = $urandom;
      send_matrix(m_rand);
      wait_drain();
    end
    rdy_mode = 0;

    check("final_q_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
